// File: rtl/piton_credit_bridge_pkg.sv
// ==== piton_credit_bridge_pkg: shared link types and helpers (rev 1.0) ====
`default_nettype none

package piton_credit_bridge_pkg;

  localparam int PITON_FLIT_W = 64;

  typedef struct packed {
    logic [PITON_FLIT_W-1:0] data;
    logic                    valid;
    logic                    yummy;
  } piton_link_t;

  // A one-entry FIFO still needs a one-bit pointer.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/piton_rx_fifo.sv
// ==== piton_rx_fifo: one channel's receive FIFO, overflow flag and yummy delay line (rev 1.0) ====
`default_nettype none

module piton_rx_fifo
  import piton_credit_bridge_pkg::*;
#(
  parameter int DATA_W     = PITON_FLIT_W,
  parameter int DEPTH      = 4,
  parameter int YUMMY_PIPE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              push_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              pop_valid_o,
  input  logic              pop_ready_i,
  output logic              yummy_o,
  output logic              ovf_err_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [PW-1:0]       rd_q, wr_q;
  logic [CW-1:0]       cnt_q;
  logic                ovf_q;
  logic [YUMMY_PIPE:0] yp_q;

  logic full, pop, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full = (cnt_q == CW'(DEPTH));
  assign pop  = (cnt_q != '0) && pop_ready_i;
  // A full FIFO still takes a flit when the head leaves in the same cycle.
  assign push = push_i && (!full || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      yp_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop) rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (push_i && full && !pop) ovf_q <= 1'b1;
      yp_q[0] <= pop;
      for (int i = 1; i <= YUMMY_PIPE; i++) yp_q[i] <= yp_q[i-1];
    end
  end

  assign pop_data_o  = mem_q[rd_q];
  assign pop_valid_o = (cnt_q != '0);
  assign yummy_o     = yp_q[YUMMY_PIPE];
  assign ovf_err_o   = ovf_q;

endmodule

`default_nettype wire

// File: rtl/piton_credit_bridge.sv
// ==== piton_credit_bridge: multi-channel piton yummy-credit <-> valid/ready bridge (rev 1.0) ====
`default_nettype none

module piton_credit_bridge
  import piton_credit_bridge_pkg::*;
#(
  parameter int DATA_W      = PITON_FLIT_W,
  parameter int NCH         = 5,
  parameter int IN_DEPTH    = 4,
  parameter int OUT_CREDITS = 4,
  parameter int YUMMY_PIPE  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH*DATA_W-1:0] p_data_in,
  input  logic [NCH-1:0]        p_valid_in,
  output logic [NCH-1:0]        p_yummy_out,
  output logic [NCH*DATA_W-1:0] q_data_out,
  output logic [NCH-1:0]        q_valid_out,
  input  logic [NCH-1:0]        q_ready_in,
  input  logic [NCH*DATA_W-1:0] q_data_in,
  input  logic [NCH-1:0]        q_valid_in,
  output logic [NCH-1:0]        q_ready_out,
  output logic [NCH*DATA_W-1:0] p_data_out,
  output logic [NCH-1:0]        p_valid_out,
  input  logic [NCH-1:0]        p_yummy_in,
  output logic [NCH-1:0]        ovf_err,
  output logic [NCH-1:0]        credit_err
);

  localparam int CRW = $clog2(OUT_CREDITS + 1);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    piton_rx_fifo #(
      .DATA_W     (DATA_W),
      .DEPTH      (IN_DEPTH),
      .YUMMY_PIPE (YUMMY_PIPE)
    ) u_rx (
      .clk         (clk),
      .reset       (reset),
      .push_data_i (p_data_in[c*DATA_W +: DATA_W]),
      .push_i      (p_valid_in[c]),
      .pop_data_o  (q_data_out[c*DATA_W +: DATA_W]),
      .pop_valid_o (q_valid_out[c]),
      .pop_ready_i (q_ready_in[c]),
      .yummy_o     (p_yummy_out[c]),
      .ovf_err_o   (ovf_err[c])
    );

    logic [CRW-1:0]    cr_q, cr_d;
    logic              cerr_q, cerr_d;
    logic              pv_q;
    logic [DATA_W-1:0] pd_q;
    logic              accept;

    // Ready is masked by reset so nothing is offered while the counter is held.
    assign q_ready_out[c] = (cr_q != '0) && reset;
    assign accept         = q_valid_in[c] && q_ready_out[c];

    always_comb begin
      cr_d   = cr_q;
      cerr_d = cerr_q;
      if (accept && !p_yummy_in[c]) begin
        cr_d = cr_q - CRW'(1);
      end else if (!accept && p_yummy_in[c]) begin
        if (cr_q == CRW'(OUT_CREDITS)) cerr_d = 1'b1;
        else                           cr_d   = cr_q + CRW'(1);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cr_q   <= CRW'(OUT_CREDITS);
        cerr_q <= 1'b0;
        pv_q   <= 1'b0;
        pd_q   <= '0;
      end else begin
        cr_q   <= cr_d;
        cerr_q <= cerr_d;
        pv_q   <= accept;
        if (accept) pd_q <= q_data_in[c*DATA_W +: DATA_W];
      end
    end

    assign p_valid_out[c]                = pv_q;
    assign p_data_out[c*DATA_W +: DATA_W] = pd_q;
    assign credit_err[c]                 = cerr_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_piton_credit_bridge.sv
// ==== tb_piton_credit_bridge: directed + randomized checks against a queue-based model (rev 1.0) ====
`timescale 1ns/1ps
`default_nettype none

module tb_piton_credit_bridge;

  localparam int DW   = 64;
  localparam int NCH  = 5;
  localparam int IND  = 4;
  localparam int OC   = 2;
  localparam int YP   = 2;
  localparam int MAXC = 6000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NCH*DW-1:0] p_data_in, q_data_out, q_data_in, p_data_out;
  logic [NCH-1:0]    p_valid_in, p_yummy_out, q_valid_out, q_ready_in;
  logic [NCH-1:0]    q_valid_in, q_ready_out, p_valid_out, p_yummy_in;
  logic [NCH-1:0]    ovf_err, credit_err;

  always #5 clk = ~clk;

  piton_credit_bridge #(
    .DATA_W(DW), .NCH(NCH), .IN_DEPTH(IND), .OUT_CREDITS(OC), .YUMMY_PIPE(YP)
  ) dut (
    .clk(clk), .reset(reset),
    .p_data_in(p_data_in), .p_valid_in(p_valid_in), .p_yummy_out(p_yummy_out),
    .q_data_out(q_data_out), .q_valid_out(q_valid_out), .q_ready_in(q_ready_in),
    .q_data_in(q_data_in), .q_valid_in(q_valid_in), .q_ready_out(q_ready_out),
    .p_data_out(p_data_out), .p_valid_out(p_valid_out), .p_yummy_in(p_yummy_in),
    .ovf_err(ovf_err), .credit_err(credit_err)
  );

  // Reference model: rx FIFOs as queues, tx as a plain credit integer.
  logic [DW-1:0] rxq [NCH][$];
  int            cr   [NCH];
  int            pend [NCH];
  bit            exp_pv [NCH];
  logic [DW-1:0] exp_pd [NCH];
  bit            m_ovf [NCH];
  bit            m_cerr [NCH];
  bit            exp_y [NCH][MAXC];
  int            chk;
  int            n_cmp, n_bad;
  int            tally;

  task automatic cmp(input string name, input int ch, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s ch%0d: got %h want %h at %0t", name, ch, act, exp, $time);
    end
  endtask

  task automatic idle();
    p_data_in  = '0; p_valid_in = '0; q_ready_in = '0;
    q_data_in  = '0; q_valid_in = '0; p_yummy_in = '0;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      rxq[c].delete();
      cr[c] = OC; pend[c] = 0; exp_pv[c] = 0; exp_pd[c] = '0;
      m_ovf[c] = 0; m_cerr[c] = 0;
      for (int i = chk; i < MAXC; i++) exp_y[c][i] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      bit full, pop, acc, y;
      full = (rxq[c].size() == IND);
      pop  = (rxq[c].size() != 0) && q_ready_in[c];
      acc  = q_valid_in[c] && (cr[c] > 0);
      y    = p_yummy_in[c];
      if (pop) begin
        void'(rxq[c].pop_front());
        if (chk + YP < MAXC) exp_y[c][chk + YP] = 1;
      end
      if (p_valid_in[c]) begin
        if (!full || pop) rxq[c].push_back(p_data_in[c*DW +: DW]);
        else              m_ovf[c] = 1;
      end
      exp_pv[c] = acc;
      if (acc) begin
        exp_pd[c] = q_data_in[c*DW +: DW];
        pend[c]++;
      end
      if (acc && !y)      cr[c]--;
      else if (y && !acc) begin
        if (cr[c] == OC) m_cerr[c] = 1;
        else             cr[c]++;
      end
    end
  endtask

  task automatic check();
    for (int c = 0; c < NCH; c++) begin
      cmp("q_valid", c, 64'(q_valid_out[c]), 64'(rxq[c].size() != 0));
      if (rxq[c].size() != 0) cmp("q_data", c, q_data_out[c*DW +: DW], rxq[c][0]);
      cmp("q_ready", c, 64'(q_ready_out[c]), 64'(cr[c] > 0));
      cmp("p_valid", c, 64'(p_valid_out[c]), 64'(exp_pv[c]));
      cmp("p_data", c, p_data_out[c*DW +: DW], exp_pd[c]);
      cmp("p_yummy", c, 64'(p_yummy_out[c]), 64'(exp_y[c][chk]));
      cmp("ovf_err", c, 64'(ovf_err[c]), 64'(m_ovf[c]));
      cmp("credit_err", c, 64'(credit_err[c]), 64'(m_cerr[c]));
    end
    chk++;
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk); #1;
    check();
    tally += int'(p_valid_out[0]);
  endtask

  task automatic reset_vals(input string tag);
    cmp({tag, "_q_valid"}, -1, 64'(q_valid_out), 64'(0));
    cmp({tag, "_q_data"}, -1, 64'(|q_data_out), 64'(0));
    cmp({tag, "_p_valid"}, -1, 64'(p_valid_out), 64'(0));
    cmp({tag, "_p_data"}, -1, 64'(|p_data_out), 64'(0));
    cmp({tag, "_p_yummy"}, -1, 64'(p_yummy_out), 64'(0));
    cmp({tag, "_q_ready"}, -1, 64'(q_ready_out), 64'(0));
    cmp({tag, "_errs"}, -1, 64'({ovf_err, credit_err}), 64'(0));
  endtask

  task automatic rand_cycles(input int n);
    int pv_pct, rd_pct;
    pv_pct = 50; rd_pct = 50;
    for (int k = 0; k < n; k++) begin
      if (k % 100 == 0) begin
        pv_pct = int'($urandom_range(20, 90));
        rd_pct = int'($urandom_range(10, 95));
      end
      for (int c = 0; c < NCH; c++) begin
        p_valid_in[c] = ($urandom % 100) < pv_pct;
        p_data_in[c*DW +: DW] = {$urandom, $urandom};
        q_ready_in[c] = ($urandom % 100) < rd_pct;
        q_valid_in[c] = ($urandom % 100) < 60;
        q_data_in[c*DW +: DW] = {$urandom, $urandom};
        if (pend[c] > 0 && ($urandom % 100) < 40) begin
          p_yummy_in[c] = 1'b1;
          pend[c]--;
        end else begin
          p_yummy_in[c] = ($urandom % 100) < 2;
        end
      end
      cycle();
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; chk = 0; tally = 0;
    idle();
    #1 reset_vals("por");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1 check();
    cmp("init_q_ready", -1, 64'(q_ready_out), 64'h1f);

    // Four flits into channel 2 with the consumer stalled.
    for (int i = 0; i < 4; i++) begin
      idle();
      p_valid_in[2] = 1'b1;
      p_data_in[2*DW +: DW] = 64'hA0 + 64'(i);
      cycle();
    end
    cmp("fill_valid", -1, 64'(q_valid_out), 64'h04);
    cmp("fill_head", 2, q_data_out[2*DW +: DW], 64'hA0);

    // Full FIFO: push with a pop is accepted.
    idle();
    p_valid_in[2] = 1'b1; p_data_in[2*DW +: DW] = 64'hA4; q_ready_in[2] = 1'b1;
    cycle();
    cmp("pushpop_ovf", -1, 64'(ovf_err), 64'h0);
    cmp("pushpop_head", 2, q_data_out[2*DW +: DW], 64'hA1);
    cmp("yummy_t1", -1, 64'(p_yummy_out), 64'h0);

    // Full FIFO: push without pop is dropped.
    idle();
    p_valid_in[2] = 1'b1; p_data_in[2*DW +: DW] = 64'hA5;
    cycle();
    cmp("ovf_set", -1, 64'(ovf_err), 64'h04);
    cmp("ovf_head", 2, q_data_out[2*DW +: DW], 64'hA1);
    cmp("yummy_t2", -1, 64'(p_yummy_out), 64'h0);
    idle();
    cycle();
    cmp("yummy_t3", -1, 64'(p_yummy_out), 64'h04);
    cmp("other_idle", -1, 64'(q_valid_out), 64'h04);

    for (int i = 0; i < 4; i++) begin
      cmp("drain_head", 2, q_data_out[2*DW +: DW], 64'hA1 + 64'(i));
      idle();
      q_ready_in[2] = 1'b1;
      cycle();
    end
    cmp("drained", -1, 64'(q_valid_out), 64'h0);
    idle();
    repeat (4) cycle();

    // Transmit: two credits, then stall, then one returned credit.
    tally = 0;
    for (int i = 0; i < 4; i++) begin
      q_valid_in[0] = 1'b1; q_data_in[0 +: DW] = 64'hB0 + 64'(i);
      cycle();
    end
    cmp("tx_two", 0, 64'(tally), 64'd2);
    cmp("tx_stall", 0, 64'(q_ready_out[0]), 64'h0);
    p_yummy_in[0] = 1'b1;
    cycle();
    p_yummy_in[0] = 1'b0;
    repeat (3) cycle();
    cmp("tx_three", 0, 64'(tally), 64'd3);
    cmp("tx_stall2", 0, 64'(q_ready_out[0]), 64'h0);

    // Accept and yummy together at one credit.
    q_valid_in[0] = 1'b0; p_yummy_in[0] = 1'b1;
    cycle();
    q_valid_in[0] = 1'b1; p_yummy_in[0] = 1'b1;
    cycle();
    cmp("acc_yummy_keep", 0, 64'(q_ready_out[0]), 64'h1);
    p_yummy_in[0] = 1'b0;
    cycle();
    cmp("acc_last", 0, 64'(q_ready_out[0]), 64'h0);
    q_valid_in[0] = 1'b0; p_yummy_in[0] = 1'b1;
    repeat (2) cycle();
    cmp("cerr_clear", -1, 64'(credit_err), 64'h0);
    cycle();
    cmp("cerr_set", -1, 64'(credit_err), 64'h01);
    cmp("cerr_ready", 0, 64'(q_ready_out[0]), 64'h1);
    idle();
    cycle();

    rand_cycles(1200);

    // Build up buffered flits and exhaust credits, then reset mid-burst.
    for (int i = 0; i < 8; i++) begin
      idle();
      p_valid_in = '1; q_valid_in = '1;
      for (int c = 0; c < NCH; c++) begin
        p_data_in[c*DW +: DW] = {$urandom, $urandom};
        q_data_in[c*DW +: DW] = {$urandom, $urandom};
      end
      cycle();
    end
    cmp("pre_rst_credits", -1, 64'(q_ready_out), 64'h0);
    cmp("pre_rst_valid", -1, 64'(q_valid_out), 64'h1f);
    #2 reset = 1'b0;
    #1 reset_vals("async");
    idle();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1 check();
    cmp("post_rst_ready", -1, 64'(q_ready_out), 64'h1f);
    cmp("post_rst_valid", -1, 64'(q_valid_out), 64'h0);

    rand_cycles(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
